// File: rtl/inst_fifo_pkg.sv
// Shared constants and entry layout for the IF->ID instruction queue.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package inst_fifo_pkg;

  localparam int          INST_FIFO_DEPTH = 4;
  // An all-zero word decodes as sll $0,$0,0, so it is a safe value to present when the queue is empty.
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } inst_entry_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for the instruction queue, with flush priority.
// Latency: pointers and count update one cycle after the push or pop is accepted.
// Backpressure: refuses a push when full, even if a pop happens in the same cycle; a flush overrides both push and pop.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_req_i,
  input  logic          stall_i,
  output logic [AW-1:0] rptr_o,
  output logic [AW-1:0] wptr_o,
  output logic [AW:0]   count_o,
  output logic          push_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop;

  // Full and empty come only from the registered count, so readyF has no path from stall or flush.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_o  = push_req_i & ~full_o & ~flush_i;
  assign pop     = ~empty_o & ~stall_i & ~flush_i;

  assign rptr_o  = rptr_q;
  assign wptr_o  = wptr_q;
  assign count_o = count_q;

  // Next-state: flush clears everything; otherwise advance pointers and adjust occupancy.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_o) wptr_d = wptr_q + PTR_ONE;
      if (pop)    rptr_d = rptr_q + PTR_ONE;
      case ({push_o, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_fifo.sv
// Instruction queue between fetch and decode; holds {instr, pc, adel} and presents the oldest entry.
// Latency: a pushed entry becomes visible on the D side one cycle later (no empty bypass).
// Backpressure: readyF is low when full; stallD holds the head; flushD discards all entries.
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic        push_validF,
  input  logic [31:0] push_instrF,
  input  logic [31:0] push_pcF,
  input  logic        push_adelF,
  output logic        readyF,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        adelD,
  output logic [AW:0] countD
);

  inst_entry_t   mem_q [DEPTH];
  inst_entry_t   head;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          push;
  logic          full;
  logic          empty;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flushD),
    .push_req_i (push_validF),
    .stall_i    (stallD),
    .rptr_o     (rptr),
    .wptr_o     (wptr),
    .count_o    (countD),
    .push_o     (push),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr] <= '{instr: push_instrF, pc: push_pcF, adel: push_adelF};
    end
  end

  // Head is a plain mux on the registered read pointer; empty masks it to a NOP.
  assign head   = mem_q[rptr];
  assign readyF = ~full;
  assign validD = ~empty;
  assign instrD = empty ? NOP_INSTR : head.instr;
  assign pcD    = empty ? 32'h0     : head.pc;
  assign adelD  = empty ? 1'b0      : head.adel;

endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;
  import inst_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        flushD;
  logic        stallD;
  logic        push_validF;
  logic [31:0] push_instrF;
  logic [31:0] push_pcF;
  logic        push_adelF;
  logic        readyF;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        adelD;
  logic [AW:0] countD;

  int n_tests = 0;
  int n_fail  = 0;

  inst_entry_t exp_q[$];

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[10];

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flushD      (flushD),
    .stallD      (stallD),
    .push_validF (push_validF),
    .push_instrF (push_instrF),
    .push_pcF    (push_pcF),
    .push_adelF  (push_adelF),
    .readyF      (readyF),
    .validD      (validD),
    .instrD      (instrD),
    .pcD         (pcD),
    .adelD       (adelD),
    .countD      (countD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h2400_5A5A;
  endfunction

  // Compare every D-side output and readyF against the scoreboard.
  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    chk("validD", {31'b0, validD}, {31'b0, sz != 0});
    chk("readyF", {31'b0, readyF}, {31'b0, sz != DEPTH});
    chk("countD", {29'b0, countD}, sz);
    if (sz != 0) begin
      chk("instrD", instrD, exp_q[0].instr);
      chk("pcD",    pcD,    exp_q[0].pc);
      chk("adelD",  {31'b0, adelD}, {31'b0, exp_q[0].adel});
    end else begin
      chk("instrD_empty", instrD, NOP_INSTR);
      chk("pcD_empty",    pcD,    32'h0);
      chk("adelD_empty",  {31'b0, adelD}, 32'h0);
    end
  endtask

  // One clock: check outputs, drive inputs, check no combinational leak, update model, advance.
  task automatic cycle(input logic r, input logic pv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ad, input logic st,
                       input logic fl);
    logic pre_valid, pre_ready;
    logic [31:0] pre_instr;
    int sz;
    check_outputs();
    pre_valid = validD;
    pre_ready = readyF;
    pre_instr = instrD;
    rst = r; push_validF = pv; push_instrF = ins; push_pcF = pc;
    push_adelF = ad; stallD = st; flushD = fl;
    #1;
    chk("nocomb_validD", {31'b0, validD}, {31'b0, pre_valid});
    chk("nocomb_readyF", {31'b0, readyF}, {31'b0, pre_ready});
    chk("nocomb_instrD", instrD, pre_instr);
    sz = exp_q.size();
    if (r || fl) begin
      exp_q.delete();
    end else begin
      if (sz != 0 && !st) void'(exp_q.pop_front());
      if (pv && sz != DEPTH) exp_q.push_back('{instr: ins, pc: pc, adel: ad});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] pc, input logic st);
    cycle(1'b0, 1'b1, ins_of(pc), pc, 1'b0, st, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Fill while stalled, refuse the 5th, pop+refused push when full, then drain.
    tbl[0] = '{pv: 1'b1, pc: 32'hBFC0_0000, stall: 1'b1, flush: 1'b0, exp_cnt: 1};
    tbl[1] = '{pv: 1'b1, pc: 32'hBFC0_0004, stall: 1'b1, flush: 1'b0, exp_cnt: 2};
    tbl[2] = '{pv: 1'b1, pc: 32'hBFC0_0008, stall: 1'b1, flush: 1'b0, exp_cnt: 3};
    tbl[3] = '{pv: 1'b1, pc: 32'hBFC0_000C, stall: 1'b1, flush: 1'b0, exp_cnt: 4};
    tbl[4] = '{pv: 1'b1, pc: 32'hBFC0_0010, stall: 1'b1, flush: 1'b0, exp_cnt: 4};
    tbl[5] = '{pv: 1'b1, pc: 32'hBFC0_0014, stall: 1'b0, flush: 1'b0, exp_cnt: 3};
    tbl[6] = '{pv: 1'b0, pc: 32'h0,         stall: 1'b0, flush: 1'b0, exp_cnt: 2};
    tbl[7] = '{pv: 1'b0, pc: 32'h0,         stall: 1'b0, flush: 1'b0, exp_cnt: 1};
    tbl[8] = '{pv: 1'b0, pc: 32'h0,         stall: 1'b0, flush: 1'b0, exp_cnt: 0};
    tbl[9] = '{pv: 1'b0, pc: 32'h0,         stall: 1'b0, flush: 1'b0, exp_cnt: 0};

    rst = 1'b1; flushD = 1'b0; stallD = 1'b0; push_validF = 1'b0;
    push_instrF = 32'h0; push_pcF = 32'h0; push_adelF = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle.
    idle(3);

    // Table-driven fill/drain with full-with-pop.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, tbl[i].pv, ins_of(tbl[i].pc), tbl[i].pc, 1'b0, tbl[i].stall, tbl[i].flush);
      chk($sformatf("tbl%0d_countD", i), {29'b0, countD}, tbl[i].exp_cnt);
    end
    idle(1);

    // Concurrent push/pop at count=2 across two pointer wraps.
    push1(32'hA000_0000, 1'b1);
    push1(32'hA000_0004, 1'b1);
    for (int i = 0; i < 10; i++) begin
      push1(32'hA000_0008 + 32'(i * 4), 1'b0);
      chk("steady_countD", {29'b0, countD}, 32'd2);
    end
    idle(3);

    // Flush priority: count=3, push and flush together.
    push1(32'hC000_0000, 1'b1);
    push1(32'hC000_0004, 1'b1);
    push1(32'hC000_0008, 1'b1);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 32'hC000_000C, 1'b0, 1'b0, 1'b1);
    chk("flush_countD", {29'b0, countD}, 32'd0);
    chk("flush_validD", {31'b0, validD}, 32'd0);
    idle(2);

    // Fetch address error into an empty queue.
    cycle(1'b0, 1'b1, 32'h1234_5678, 32'hBFC0_0002, 1'b1, 1'b1, 1'b0);
    chk("adel_validD", {31'b0, validD}, 32'd1);
    chk("adel_pcD", pcD, 32'hBFC0_0002);
    chk("adel_adelD", {31'b0, adelD}, 32'd1);
    chk("adel_instrD", instrD, 32'h1234_5678);
    idle(2);

    // Reset mid-operation behaves like a flush.
    push1(32'hE000_0000, 1'b1);
    push1(32'hE000_0004, 1'b1);
    cycle(1'b1, 1'b1, 32'h0, 32'hE000_0008, 1'b0, 1'b0, 1'b0);
    chk("midrst_countD", {29'b0, countD}, 32'd0);
    push1(32'hF000_0000, 1'b1);
    push1(32'hF000_0004, 1'b0);
    idle(3);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
